// File: rtl/ibex_trace_pkg.sv
// ibex_trace_pkg
//   Shared types for the trace event buffer: record type codes, the packed
//   trace record and helpers classifying which codes are legal on each lane.
//   No ports (package).
package ibex_trace_pkg;

    localparam int unsigned TRACE_REC_W = 116;

    typedef enum logic [2:0] {
        TR_NONE          = 3'd0,
        TR_IF            = 3'd1,
        TR_IF_START      = 3'd2,
        TR_IF_END        = 3'd3,
        TR_IDEX          = 3'd4,
        TR_IDEX_MULT_END = 3'd5,
        TR_RSVD6         = 3'd6,
        TR_OVERFLOW      = 3'd7
    } trace_type_e;

    typedef struct packed {
        trace_type_e ttype;
        logic [31:0] ts;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        c;
        logic [15:0] c_insn;
    } trace_rec_t;

    function automatic logic is_fe_type(logic [2:0] t);
        return (t == TR_IF) || (t == TR_IF_START) || (t == TR_IF_END);
    endfunction

    function automatic logic is_ex_type(logic [2:0] t);
        return (t == TR_IDEX) || (t == TR_IDEX_MULT_END);
    endfunction

endpackage

// File: rtl/ibex_trace_event_buffer_if.sv
// ibex_trace_event_buffer_if
//   Bundles the two event lanes (fetch, idex) and the ready/valid record
//   stream of the trace event buffer.
//   slave  : buffer side (events in, records out)
//   master : detector/consumer side
//   DEPTH sizes the level field ($clog2(DEPTH)+1 bits).
interface ibex_trace_event_buffer_if
    import ibex_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          fe_valid;
    logic [2:0]    fe_type;
    logic [31:0]   fe_pc;
    logic [31:0]   fe_insn;
    logic          fe_c;
    logic [15:0]   fe_c_insn;
    logic          ex_valid;
    logic [2:0]    ex_type;
    logic [31:0]   ex_pc;
    logic          out_valid;
    logic          out_ready;
    trace_rec_t    out_rec;
    logic [LW-1:0] level;

    modport slave (
        input  fe_valid, fe_type, fe_pc, fe_insn, fe_c, fe_c_insn,
        input  ex_valid, ex_type, ex_pc, out_ready,
        output out_valid, out_rec, level
    );

    modport master (
        output fe_valid, fe_type, fe_pc, fe_insn, fe_c, fe_c_insn,
        output ex_valid, ex_type, ex_pc, out_ready,
        input  out_valid, out_rec, level
    );

endinterface

// File: rtl/ibex_trace_buf_mem.sv
// ibex_trace_buf_mem
//   DEPTH x trace_rec_t record storage. Up to three writes per cycle (the
//   caller places them at consecutive wrapped indices), one registered read.
//   A write landing on the address being read is forwarded into the read
//   register so a record written into an empty buffer is visible next cycle.
//   clk, rst_n        : clock, async active-low reset (clears read register)
//   we_i/waddr_i/wdata_i : three write ports
//   raddr_i           : address to present on rdata_o after the next edge
//   rdata_o           : registered read data
module ibex_trace_buf_mem
    import ibex_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    we_i,
    input  logic [AW-1:0] waddr_i [3],
    input  trace_rec_t    wdata_i [3],
    input  logic [AW-1:0] raddr_i,
    output trace_rec_t    rdata_o
);

    trace_rec_t mem_q [DEPTH];
    trace_rec_t rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 3; k++) begin
            if (we_i[k]) mem_q[waddr_i[k]] <= wdata_i[k];
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr_i];
        for (int unsigned k = 0; k < 3; k++) begin
            if (we_i[k] && (waddr_i[k] == raddr_i)) rdata_d = wdata_i[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ibex_trace_event_buffer.sv
// ibex_trace_event_buffer
//   Timestamps fetch- and idex-lane trace events, buffers them in order and
//   streams records out over ready/valid. Events that do not fit are dropped
//   and counted; the loss is reported in-order by an OVERFLOW record.
//   clk, rst_n : clock, async active-low reset
//   bus        : ibex_trace_event_buffer_if.slave (event lanes, record stream, level)
//   Build macro IBEX_TRACE_TIMESTAMP_EN: when defined a free-running 32-bit
//   cycle counter timestamps records; otherwise ts is constant 0.
module ibex_trace_event_buffer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input logic clk,
    input logic rst_n,
    ibex_trace_event_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]     level_q, level_d, free;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d, drop_base;
    logic [DROP_W:0]   drop_sum;
    logic              drop_pend_q, drop_pend_d;
    logic [31:0]       ts_now;
    logic              pop, ov_wr;
    logic [1:0]        n_wr, n_drop;
    logic [2:0]        req, we;
    logic [AW-1:0]     waddr [3];
    trace_rec_t        wdata [3];
    trace_rec_t        cand  [3];
    trace_rec_t        rdata;

`ifdef IBEX_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 32'd1;
    end

    assign ts_now = ts_q;
`else
    assign ts_now = '0;
`endif

    assign bus.out_valid = (level_q != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    // A pop this cycle frees its slot for a same-cycle write.
    assign free          = LW'(DEPTH) - level_q + LW'(pop);
    assign ov_wr         = drop_pend_q && (free != '0);

    // Candidates in write-priority order: pending OVERFLOW, fetch, idex.
    // Each one that fits takes the next consecutive slot; lane events that
    // do not fit are dropped (a pending OVERFLOW simply waits).
    always_comb begin
        req     = {bus.ex_valid, bus.fe_valid, drop_pend_q};
        cand[0] = '{ttype: TR_OVERFLOW, ts: ts_now, pc: 32'(drop_cnt_q),
                    insn: '0, c: 1'b0, c_insn: '0};
        cand[1] = '{ttype: trace_type_e'(bus.fe_type), ts: ts_now, pc: bus.fe_pc,
                    insn: bus.fe_insn, c: bus.fe_c, c_insn: bus.fe_c_insn};
        cand[2] = '{ttype: trace_type_e'(bus.ex_type), ts: ts_now, pc: bus.ex_pc,
                    insn: '0, c: 1'b0, c_insn: '0};
        we      = '0;
        n_wr    = '0;
        n_drop  = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            waddr[k] = wp_q + AW'(k);
            wdata[k] = '0;
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (req[i]) begin
                if (LW'(n_wr) < free) begin
                    we[n_wr]    = 1'b1;
                    wdata[n_wr] = cand[i];
                    n_wr        = n_wr + 2'd1;
                end else if (i != 0) begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    // Writing OVERFLOW restarts the count; drops in the same cycle count afresh.
    always_comb begin
        drop_base   = ov_wr ? '0 : drop_cnt_q;
        drop_sum    = {1'b0, drop_base} + (DROP_W+1)'(n_drop);
        drop_cnt_d  = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        drop_pend_d = (n_drop != '0) || (drop_pend_q && !ov_wr);
        level_d     = level_q + LW'(n_wr) - LW'(pop);
        wp_d        = wp_q + AW'(n_wr);
        rp_d        = rp_q + AW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            drop_cnt_q  <= '0;
            drop_pend_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            level_q     <= level_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_pend_q <= drop_pend_d;
        end
    end

    ibex_trace_buf_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rp_d),
        .rdata_o (rdata)
    );

    assign bus.out_rec = rdata;
    assign bus.level   = level_q;

`ifndef SYNTHESIS
    fe_type_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fe_valid |-> is_fe_type(bus.fe_type));
    ex_type_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.ex_valid |-> is_ex_type(bus.ex_type));
`endif

endmodule

// File: tb/tb_ibex_trace_event_buffer.sv
// tb_ibex_trace_event_buffer
//   Self-checking bench: per-cycle vector table plus hand-written fill,
//   overflow, pop-through and mid-stream reset sequences.
module tb_ibex_trace_event_buffer;
    import ibex_trace_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] tb_ts;
    int          checks = 0;
    int          errors = 0;
    trace_rec_t  expq [$];

    ibex_trace_event_buffer_if #(.DEPTH(16)) bus ();

    ibex_trace_event_buffer #(
        .DEPTH  (16),
        .DROP_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: the timestamp an event driven now receives.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000ns");
        $fatal(1);
    end

    typedef struct {
        logic        fev;
        logic [2:0]  fet;
        logic [31:0] fepc;
        logic [31:0] feinsn;
        logic        fec;
        logic [15:0] feci;
        logic        exv;
        logic [2:0]  ext;
        logic [31:0] expc;
        logic        rdy;
        logic        ev;
        trace_rec_t  erec;
        logic [4:0]  elvl;
    } vec_t;

    vec_t tbl [14];

    function automatic trace_rec_t erec(trace_type_e t, logic [31:0] ts, logic [31:0] pc,
                                        logic [31:0] insn, logic c, logic [15:0] ci);
        trace_rec_t r;
        r.ttype  = t;
`ifdef IBEX_TRACE_TIMESTAMP_EN
        r.ts     = ts;
`else
        r.ts     = (ts == ts) ? 32'd0 : 32'd0;
`endif
        r.pc     = pc;
        r.insn   = insn;
        r.c      = c;
        r.c_insn = ci;
        return r;
    endfunction

    function automatic vec_t mkv(logic fev, logic [2:0] fet, logic [31:0] fepc, logic [31:0] feinsn,
                                 logic fec, logic [15:0] feci, logic exv, logic [2:0] ext,
                                 logic [31:0] expc, logic rdy, logic ev, trace_rec_t r,
                                 logic [4:0] elvl);
        vec_t v;
        v.fev = fev; v.fet = fet; v.fepc = fepc; v.feinsn = feinsn; v.fec = fec; v.feci = feci;
        v.exv = exv; v.ext = ext; v.expc = expc; v.rdy = rdy;
        v.ev = ev; v.erec = r; v.elvl = elvl;
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic fev, logic [2:0] fet, logic [31:0] fepc, logic [31:0] feinsn,
                         logic fec, logic [15:0] feci, logic exv, logic [2:0] ext,
                         logic [31:0] expc, logic rdy);
        bus.fe_valid  = fev;
        bus.fe_type   = fet;
        bus.fe_pc     = fepc;
        bus.fe_insn   = feinsn;
        bus.fe_c      = fec;
        bus.fe_c_insn = feci;
        bus.ex_valid  = exv;
        bus.ex_type   = ext;
        bus.ex_pc     = expc;
        bus.out_ready = rdy;
    endtask

    task automatic idle(logic rdy);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 3'd0, 32'd0, rdy);
    endtask

    // Pops every expected record in order (out_ready=1, no events), then
    // requires an empty buffer.
    task automatic drain(string nm);
        int unsigned guard = 0;
        while (expq.size() != 0 && guard < 200) begin
            if (bus.out_valid) chk({nm, "_rec"}, 128'(bus.out_rec), 128'(expq.pop_front()));
            idle(1'b1);
            @(negedge clk);
            guard++;
        end
        if (expq.size() != 0) begin
            chk({nm, "_timeout_left"}, 128'(expq.size()), 128'd0);
            expq.delete();
        end
        chk({nm, "_end_valid"}, 128'(bus.out_valid), 128'd0);
        chk({nm, "_end_level"}, 128'(bus.level), 128'd0);
    endtask

    initial begin
        // Rows: inputs driven for cycle r; expectations are outputs one cycle later.
        for (int unsigned r = 0; r < 5; r++)
            tbl[r] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5'd0);
        tbl[5]  = mkv(1, 3'd1, 32'h80, 32'h13, 0, 0, 0, 0, 0, 1,
                      1, erec(TR_IF, 5, 32'h80, 32'h13, 0, 0), 5'd1);
        tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5'd0);
        tbl[7]  = mkv(1, 3'd3, 32'h100, 32'h8067, 0, 0, 1, 3'd4, 32'hFC, 1,
                      1, erec(TR_IF_END, 7, 32'h100, 32'h8067, 0, 0), 5'd2);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, erec(TR_IDEX, 7, 32'hFC, 0, 0, 0), 5'd1);
        tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5'd0);
        tbl[10] = mkv(1, 3'd2, 32'h0, 32'h50513, 1, 16'h4501, 0, 0, 0, 0,
                      1, erec(TR_IF_START, 10, 0, 32'h50513, 1, 16'h4501), 5'd1);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 1, 3'd5, 32'h200, 0,
                      1, erec(TR_IF_START, 10, 0, 32'h50513, 1, 16'h4501), 5'd2);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, erec(TR_IDEX_MULT_END, 11, 32'h200, 0, 0, 0), 5'd1);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5'd0);

        rst_n = 1'b0;
        idle(1'b1);
        repeat (3) @(negedge clk);
        chk("reset_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_level", 128'(bus.level), 128'd0);
        chk("reset_rec", 128'(bus.out_rec), 128'd0);
        rst_n = 1'b1;

        for (int unsigned r = 0; r < 14; r++) begin
            drive(tbl[r].fev, tbl[r].fet, tbl[r].fepc, tbl[r].feinsn, tbl[r].fec, tbl[r].feci,
                  tbl[r].exv, tbl[r].ext, tbl[r].expc, tbl[r].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", r), 128'(bus.out_valid), 128'(tbl[r].ev));
            chk($sformatf("vec%0d_level", r), 128'(bus.level), 128'(tbl[r].elvl));
            if (tbl[r].ev) chk($sformatf("vec%0d_rec", r), 128'(bus.out_rec), 128'(tbl[r].erec));
        end

        // Stalled consumer, 20 fetch events: 16 stored, 4 dropped.
        for (int unsigned i = 0; i < 20; i++) begin
            drive(1, 3'd1, 32'h1000 + 32'(4*i), 32'(i), 0, 0, 0, 0, 0, 0);
            if (i < 16) expq.push_back(erec(TR_IF, tb_ts, 32'h1000 + 32'(4*i), 32'(i), 0, 0));
            @(negedge clk);
        end
        idle(1'b0);
        chk("fill_level", 128'(bus.level), 128'd16);
        chk("fill_hold_rec", 128'(bus.out_rec), 128'(expq[0]));
        idle(1'b1);
        expq.push_back(erec(TR_OVERFLOW, tb_ts, 32'd4, 0, 0, 0));
        drain("ovf4");

        // Full with pop-through: fe fits, ex dropped, OVERFLOW pc=1 follows.
        for (int unsigned i = 0; i < 16; i++) begin
            drive(1, 3'd1, 32'h2000 + 32'(4*i), 32'(i), 0, 0, 0, 0, 0, 0);
            expq.push_back(erec(TR_IF, tb_ts, 32'h2000 + 32'(4*i), 32'(i), 0, 0));
            @(negedge clk);
        end
        idle(1'b0);
        chk("full_level", 128'(bus.level), 128'd16);
        chk("full_head", 128'(bus.out_rec), 128'(expq.pop_front()));
        drive(1, 3'd1, 32'h3000, 32'hAA, 0, 0, 1, 3'd4, 32'h3004, 1);
        expq.push_back(erec(TR_IF, tb_ts, 32'h3000, 32'hAA, 0, 0));
        @(negedge clk);
        chk("popthru_level", 128'(bus.level), 128'd16);
        idle(1'b1);
        expq.push_back(erec(TR_OVERFLOW, tb_ts, 32'd1, 0, 0, 0));
        drain("ovf1");

        // Asynchronous reset mid-stream.
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1, 3'd1, 32'h4000 + 32'(4*i), 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        idle(1'b0);
        chk("pre_rst_valid", 128'(bus.out_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_mid_level", 128'(bus.level), 128'd0);
        chk("rst_mid_rec", 128'(bus.out_rec), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3'd1, 32'h500, 32'h13, 0, 0, 0, 0, 0, 1);
        expq.push_back(erec(TR_IF, 32'd0, 32'h500, 32'h13, 0, 0));
        @(negedge clk);
        chk("post_rst_valid", 128'(bus.out_valid), 128'd1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
